// File: rtl/writeback_pkg.sv
// writeback_pkg: opcodes, load funct3 codes, FSM states and the load misalignment rule.
package writeback_pkg;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    typedef enum logic {IDLE, WAIT_LOAD} state_e;
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == F3_LH || f3 == F3_LHU) && off[0]) || (f3 == F3_LW && off != 2'b00);
    endfunction
endpackage

// File: rtl/writeback_control_if.sv
// writeback_control_if: instruction, memory response and register-file write signals.
// MISALIGN exists only when WB_MISALIGN_CHECK_EN is defined.
interface writeback_control_if #(parameter int XLEN = 32);
    logic            IN_VALID;
    logic            IN_READY;
    logic [6:0]      OPCODE;
    logic [2:0]      FUNCT3;
    logic [4:0]      RD;
    logic [XLEN-1:0] ALU_RESULT;
    logic [XLEN-1:0] PC;
    logic            MEM_RVALID;
    logic [XLEN-1:0] MEM_RDATA;
    logic            RF_WE;
    logic [4:0]      RF_WADDR;
    logic [XLEN-1:0] RF_WDATA;
    logic            BUSY;
`ifdef WB_MISALIGN_CHECK_EN
    logic            MISALIGN;
    modport slave (input IN_VALID, OPCODE, FUNCT3, RD, ALU_RESULT, PC, MEM_RVALID, MEM_RDATA,
                   output IN_READY, RF_WE, RF_WADDR, RF_WDATA, BUSY, MISALIGN);
    modport master (output IN_VALID, OPCODE, FUNCT3, RD, ALU_RESULT, PC, MEM_RVALID, MEM_RDATA,
                    input IN_READY, RF_WE, RF_WADDR, RF_WDATA, BUSY, MISALIGN);
`else
    modport slave (input IN_VALID, OPCODE, FUNCT3, RD, ALU_RESULT, PC, MEM_RVALID, MEM_RDATA,
                   output IN_READY, RF_WE, RF_WADDR, RF_WDATA, BUSY);
    modport master (output IN_VALID, OPCODE, FUNCT3, RD, ALU_RESULT, PC, MEM_RVALID, MEM_RDATA,
                    input IN_READY, RF_WE, RF_WADDR, RF_WDATA, BUSY);
`endif
endinterface

// File: rtl/load_align.sv
// load_align: selects the addressed byte/halfword of a raw memory word and extends it.
module load_align
    import writeback_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b    = mem_rdata[{offset, 3'b000} +: 8];
        h    = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
               funct3 == F3_LBU ? {24'b0, b} :
               funct3 == F3_LH  ? {{16{h[15]}}, h} :
               funct3 == F3_LHU ? {16'b0, h} : mem_rdata;
    end
endmodule

// File: rtl/writeback_control.sv
// writeback_control: picks ALU result, PC+4 or aligned load data for one registered RF write per writing
// instruction, stalling while a load is outstanding. WB_MISALIGN_CHECK_EN adds the MISALIGN pulse.
module writeback_control
    import writeback_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic                CLK,
    input logic                RESET_N,
    writeback_control_if.slave bus
);
    state_e          state_q, state_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      off_q, off_d;
    logic [XLEN-1:0] aligned;
    logic            wr_alu, wr_link, ld_ok;
`ifdef WB_MISALIGN_CHECK_EN
    logic            misalign_q, misalign_d;
    assign ld_ok        = !misaligned(funct3_q, off_q);
    assign bus.MISALIGN = misalign_q;
`else
    assign ld_ok = 1'b1;
`endif
    load_align u_align (
        .mem_rdata(bus.MEM_RDATA),
        .funct3   (funct3_q),
        .offset   (off_q),
        .data     (aligned)
    );
    assign wr_alu       = bus.OPCODE == OP_IMM || bus.OPCODE == OP || bus.OPCODE == LUI || bus.OPCODE == AUIPC;
    assign wr_link      = bus.OPCODE == JAL || bus.OPCODE == JALR;
    assign bus.IN_READY = state_q == IDLE;
    assign bus.BUSY     = state_q == WAIT_LOAD;
    assign bus.RF_WE    = rf_we_q;
    assign bus.RF_WADDR = rf_waddr_q;
    assign bus.RF_WDATA = rf_wdata_q;
    always_comb begin
        state_d    = state_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
`ifdef WB_MISALIGN_CHECK_EN
        misalign_d = 1'b0;
`endif
        if (state_q == IDLE && bus.IN_VALID) begin
            if (wr_alu || wr_link) begin
                rf_we_d = |bus.RD;
                if (rf_we_d) begin
                    rf_waddr_d = bus.RD;
                    rf_wdata_d = wr_link ? bus.PC + XLEN'(4) : bus.ALU_RESULT;
                end
            end else if (bus.OPCODE == LOAD) begin
                rd_d     = bus.RD;
                funct3_d = bus.FUNCT3;
                off_d    = bus.ALU_RESULT[1:0];
                state_d  = WAIT_LOAD;
            end
        end else if (state_q == WAIT_LOAD && bus.MEM_RVALID) begin
            state_d = IDLE;
            rf_we_d = ld_ok && |rd_q;
            if (rf_we_d) begin
                rf_waddr_d = rd_q;
                rf_wdata_d = aligned;
            end
`ifdef WB_MISALIGN_CHECK_EN
            misalign_d = !ld_ok;
`endif
        end
    end
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            off_q      <= '0;
`ifdef WB_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
`ifdef WB_MISALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end
endmodule

// File: tb/tb_writeback_control.sv
// tb_writeback_control: directed cases plus randomized traffic against a transaction-level reference model.
module tb_writeback_control;
    import writeback_pkg::*;
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int   errors = 0;
    int   checks = 0;
    writeback_control_if bus ();
    writeback_control dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));
    always #5 CLK = ~CLK;
    bit          pend;
    logic [4:0]  p_rd;
    logic [2:0]  p_f3;
    logic [1:0]  p_off;
    logic        exp_we, exp_mis;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [6:0]  ops [10] = '{OP_IMM, OP, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH, 7'b1110011};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] v;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (w >> (16 * off[1])) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end else v = w;
        return v;
    endfunction
    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [1:0] off);
`ifdef WB_MISALIGN_CHECK_EN
        return ((f3 == 3'd1 || f3 == 3'd5) && off % 2 == 1) || (f3 == 3'd2 && off != 0);
`else
        return 1'b0;
`endif
    endfunction
    task automatic model_reset();
        pend = 0; p_rd = 0; p_f3 = 0; p_off = 0;
        exp_we = 0; exp_mis = 0; exp_waddr = 0; exp_wdata = 0;
    endtask
    task automatic write_expect(input logic [4:0] rd, input logic [31:0] val);
        exp_we = rd != 0;
        if (rd != 0) begin
            exp_waddr = rd;
            exp_wdata = val;
        end
    endtask
    task automatic check_outputs();
        check("rf_we", bus.RF_WE, exp_we);
        check("rf_waddr", bus.RF_WADDR, exp_waddr);
        check("rf_wdata", bus.RF_WDATA, exp_wdata);
`ifdef WB_MISALIGN_CHECK_EN
        check("misalign", bus.MISALIGN, exp_mis);
`endif
    endtask
    task automatic cycle(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc, input logic mrv, input logic [31:0] mrd);
        bus.IN_VALID = v; bus.OPCODE = opc; bus.FUNCT3 = f3; bus.RD = rd;
        bus.ALU_RESULT = alu; bus.PC = pc; bus.MEM_RVALID = mrv; bus.MEM_RDATA = mrd;
        check("in_ready", bus.IN_READY, !pend);
        check("busy", bus.BUSY, pend);
        exp_we = 0;
        exp_mis = 0;
        if (!pend && v) begin
            if (opc == OP_IMM || opc == OP || opc == LUI || opc == AUIPC) write_expect(rd, alu);
            else if (opc == JAL || opc == JALR) write_expect(rd, pc + 32'd4);
            else if (opc == LOAD) begin
                pend = 1; p_rd = rd; p_f3 = f3; p_off = alu[1:0];
            end
        end else if (pend && mrv) begin
            pend = 0;
            if (ref_misaligned(p_f3, p_off)) exp_mis = 1;
            else write_expect(p_rd, ref_load(mrd, p_f3, p_off));
        end
        @(posedge CLK);
        #1;
        check_outputs();
    endtask
    task automatic idle(input logic mrv, input logic [31:0] mrd);
        cycle(1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, mrv, mrd);
    endtask
    initial begin
        model_reset();
        bus.IN_VALID = 0; bus.OPCODE = 0; bus.FUNCT3 = 0; bus.RD = 0;
        bus.ALU_RESULT = 0; bus.PC = 0; bus.MEM_RVALID = 0; bus.MEM_RDATA = 0;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        check("reset_ready", bus.IN_READY, 1);
        check("reset_busy", bus.BUSY, 0);
        check_outputs();
        cycle(1, OP_IMM, 3'd0, 5'd5, 32'h0000_1234, 32'h100, 0, 0);
        check("addi_we", bus.RF_WE, 1);
        check("addi_waddr", bus.RF_WADDR, 5);
        check("addi_wdata", bus.RF_WDATA, 32'h0000_1234);
        cycle(1, JAL, 3'd0, 5'd1, 32'h0, 32'hFFFF_FFFC, 0, 0);
        check("jal_wrap", bus.RF_WDATA, 32'h0);
        cycle(1, LOAD, F3_LB, 5'd7, 32'h103, 32'h0, 1, 32'hDEAD_BEEF);
        idle(0, 0);
        idle(0, 0);
        check("lb_busy", bus.BUSY, 1);
        check("lb_no_we", bus.RF_WE, 0);
        idle(1, 32'h80FF_0011);
        check("lb_sext", bus.RF_WDATA, 32'hFFFF_FF80);
        check("lb_waddr", bus.RF_WADDR, 7);
        cycle(1, LOAD, F3_LHU, 5'd9, 32'h2, 32'h0, 0, 0);
        idle(1, 32'hBEEF_1234);
        check("lhu", bus.RF_WDATA, 32'h0000_BEEF);
        cycle(1, LOAD, F3_LH, 5'd9, 32'h2, 32'h0, 0, 0);
        idle(1, 32'hBEEF_1234);
        check("lh", bus.RF_WDATA, 32'hFFFF_BEEF);
        cycle(1, OP, 3'd0, 5'd0, 32'h55, 32'h0, 0, 0);
        check("rd0_we", bus.RF_WE, 0);
        cycle(1, STORE, F3_LW, 5'd3, 32'h40, 32'h0, 0, 0);
        check("sw_we", bus.RF_WE, 0);
        check("sw_ready", bus.IN_READY, 1);
        cycle(1, LOAD, F3_LW, 5'd4, 32'h10, 32'h0, 0, 0);
        idle(0, 0);
        RESET_N = 1'b0;
        #2;
        model_reset();
        RESET_N = 1'b1;
        check("rst_busy", bus.BUSY, 0);
        idle(1, 32'h1234_5678);
        check("rst_drop_we", bus.RF_WE, 0);
        check("rst_state", bus.IN_READY, 1);
`ifdef WB_MISALIGN_CHECK_EN
        cycle(1, LOAD, F3_LW, 5'd6, 32'h1, 32'h0, 0, 0);
        idle(1, 32'hCAFE_F00D);
        check("mis_pulse", bus.MISALIGN, 1);
        check("mis_no_we", bus.RF_WE, 0);
        idle(0, 0);
        check("mis_clear", bus.MISALIGN, 0);
`endif
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, ops[$urandom_range(0, 9)], 3'($urandom),
                  $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom), $urandom, $urandom,
                  $urandom_range(0, 2) == 0, $urandom);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/writeback_control.md
# writeback_control

Result-side counterpart of the ALU operand selection logic. Takes each retiring instruction's ALU result, PC and decoded fields. Chooses the value written back to the register file: ALU result, PC+4, or aligned and extended load data. It holds the pipeline while a load's memory response is outstanding and produces one registered register-file write per writing instruction.

## Interface
Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  instruction presented on the fields below.
- IN_READY  out  1  block accepts the instruction this cycle.
- OPCODE  in  7  RV32I opcode.
- FUNCT3  in  3  instruction funct3.
- RD  in  5  destination register.
- ALU_RESULT  in  32  ALU output; for loads/stores this is the effective address.
- PC  in  32  instruction PC.
- MEM_RVALID  in  1  load data valid, single-cycle pulse.
- MEM_RDATA  in  32  raw word read from memory; not shifted.
- RF_WE  out  1  register-file write enable, one-cycle pulse.
- RF_WADDR  out  5  write address.
- RF_WDATA  out  32  write data.
- BUSY  out  1  a load is outstanding.

## Operation
- States: IDLE, WAIT_LOAD.
- Accept: an instruction is accepted when IN_VALID && IN_READY. IN_READY = (state == IDLE).
- IDLE, accepted instruction with a writing opcode:
  - Writing opcodes are OP-IMM 0010011, OP 0110011, LUI 0110111 and AUIPC 0010111. Next cycle: RF_WE=1, RF_WDATA=ALU_RESULT.
  - JAL 1101111 and JALR 1100111: next cycle RF_WE=1, RF_WDATA=PC+4 (modulo 2^32).
- IDLE, accepted load 0000011:
  - Capture RD, FUNCT3 and ALU_RESULT[1:0] (byte offset); go to WAIT_LOAD. No write yet.
- IDLE, accepted store 0100011, branch 1100011 or any other opcode: consumed, no write.
- WAIT_LOAD, MEM_RVALID=1:
  - Next cycle RF_WE=1, RF_WADDR=captured RD, RF_WDATA=aligned data; return to IDLE.
  - The block can accept a new instruction in the cycle after MEM_RVALID.
- Load alignment, with offset = captured ALU_RESULT[1:0]:
  - LB 000: MEM_RDATA byte[offset], sign-extended.
  - LBU 100: MEM_RDATA byte[offset], zero-extended.
  - LH 001: halfword[offset[1]], sign-extended. LHU 101: halfword[offset[1]], zero-extended.
  - LW 010: full word.
  - Undefined funct3 (011, 110, 111): full word.
- RD==0: RF_WE stays 0 for every instruction. The load still waits for MEM_RVALID.
- MEM_RVALID while in IDLE, including the accept cycle of a load: ignored.
- RF_WADDR and RF_WDATA are don't-care when RF_WE=0, but must hold their last values (no toggling).

## Timing
- Reset values: state=IDLE, RF_WE=0, RF_WADDR=0, RF_WDATA=0, BUSY=0; IN_READY=1 after reset.
- Reset asserted mid-WAIT_LOAD: the pending load is dropped and no write occurs. A MEM_RVALID after reset release is ignored.
- Non-load latency: 1 cycle from accept to RF_WE. Sustained throughput is 1 instruction/cycle with RF_WE every cycle.
- Load latency: 1 cycle after MEM_RVALID. The memory may take any number of cycles ≥1 after accept.
- BUSY = (state == WAIT_LOAD), driven from the state register.

## Configuration
- WB_MISALIGN_CHECK_EN defined:
  - Adds output MISALIGN (1 bit, reset 0). It detects LH/LHU with offset[0]=1 and LW with offset≠0.
  - The load still waits for MEM_RVALID. In the cycle after MEM_RVALID, MISALIGN=1 for one cycle and RF_WE=0.
- Macro undefined: no MISALIGN port. Misaligned loads use the alignment rules above, ignoring the low offset bits.

## Structure
- Package writeback_pkg holds:
  - opcode localparams (OP_IMM, OP, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH);
  - load funct3 localparams;
  - a state typedef enum {IDLE, WAIT_LOAD}.
- Sub-module load_align: purely combinational; inputs MEM_RDATA, FUNCT3, offset; output 32-bit extended data. It is instantiated once.

## Test plan
- ADDI path: accept OPCODE=0010011, RD=5, ALU_RESULT=0x0000_1234 -> next cycle RF_WE=1, RF_WADDR=5, RF_WDATA=0x0000_1234.
- JAL: PC=0xFFFF_FFFC, RD=1 -> RF_WDATA=0x0000_0000 (wrap).
- LB sign-extend: load with FUNCT3=000, ALU_RESULT=0x103, RD=7. MEM_RVALID 3 cycles later with MEM_RDATA=0x80FF_0011:
  - IN_READY=0 and BUSY=1 while waiting;
  - then RF_WDATA=0xFFFF_FF80.
- LHU: offset 2, MEM_RDATA=0xBEEF_1234 -> RF_WDATA=0x0000_BEEF. LH at the same offset -> 0xFFFF_BEEF.
- RD=0 and store: ADD to RD=0 -> RF_WE stays 0. SW -> no write; IN_READY stays 1.
- Reset during WAIT_LOAD: then MEM_RVALID=1 -> no RF_WE, state IDLE. With WB_MISALIGN_CHECK_EN, LW at offset 1 -> MISALIGN pulse, RF_WE=0.
